// File: rtl/switch_allocator_sep.sv
// -----------------------------------------------------------------------------
// switch_allocator_sep
//
// Separable input-first switch allocator for the virtual-channel router.
//   Stage 1: per input port, a round-robin pick among VCs whose requested
//            output is ready this cycle.
//   Stage 2: per output port, a round-robin pick among the inputs whose
//            stage-1 winner targets that output.
// Grants are registered: a request presented in cycle t shows up as a grant
// in cycle t+1, for one cycle only. Pointers advance iSLIP-style, and only
// on a grant that made it through both stages.
//
// Ports
//   clk          clock, all state on the rising edge
//   reset        asynchronous, active-high reset
//   vc_out_req   [input][vc] one-hot requested output port (0 = idle)
//   out_ready    per output port: can accept a flit this cycle
//   grant_valid  per input port: a flit was granted
//   grant_vc     per input port: one-hot granted VC (0 when not granted)
//   xbar_sel     [output][input] one-hot winning input (0 when idle)
// -----------------------------------------------------------------------------
module switch_allocator_sep #(
    parameter int NUM_PORTS = 4,
    parameter int NUM_VCS   = 2
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [NUM_PORTS-1:0][NUM_VCS-1:0][NUM_PORTS-1:0] vc_out_req,
    input  logic [NUM_PORTS-1:0]                           out_ready,
    output logic [NUM_PORTS-1:0]                           grant_valid,
    output logic [NUM_PORTS-1:0][NUM_VCS-1:0]              grant_vc,
    output logic [NUM_PORTS-1:0][NUM_PORTS-1:0]            xbar_sel
);

    localparam int VW = (NUM_VCS   > 1) ? $clog2(NUM_VCS)   : 1;
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Position `off` steps after `base` in a ring of size n, without relying
    // on natural counter overflow (n need not be a power of two).
    function automatic int wrap_add(input int base, input int off, input int n);
        int s;
        s = base + off;
        if (s >= n) s = s - n;
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [NUM_PORTS-1:0][VW-1:0]            ptr1_q, ptr1_d;   // per-input VC pointer
    logic [NUM_PORTS-1:0][PW-1:0]            ptr2_q, ptr2_d;   // per-output input pointer
    logic [NUM_PORTS-1:0]                    grant_valid_q, grant_valid_d;
    logic [NUM_PORTS-1:0][NUM_VCS-1:0]       grant_vc_q, grant_vc_d;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]     xbar_sel_q, xbar_sel_d;

    // -------------------------------------------------------------------------
    // Request qualification
    // A multi-hot request is reduced to its lowest set bit; the downward scan
    // leaves the lowest bit as the last (surviving) assignment.
    // -------------------------------------------------------------------------
    logic [NUM_PORTS-1:0][NUM_VCS-1:0][NUM_PORTS-1:0] req_tgt;
    logic [NUM_PORTS-1:0][NUM_VCS-1:0]                req_elig;

    always_comb begin
        req_tgt  = '0;
        req_elig = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                for (int b = NUM_PORTS - 1; b >= 0; b--) begin
                    if (vc_out_req[i][v][b]) begin
                        req_tgt[i][v]    = '0;
                        req_tgt[i][v][b] = 1'b1;
                    end
                end
                req_elig[i][v] = |(req_tgt[i][v] & out_ready);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: per input, first eligible VC starting at ptr1
    // -------------------------------------------------------------------------
    logic [NUM_PORTS-1:0]                s1_valid;
    logic [NUM_PORTS-1:0][VW-1:0]        s1_vc;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] s1_tgt;

    always_comb begin
        s1_valid = '0;
        s1_vc    = '0;
        s1_tgt   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int k = 0; k < NUM_VCS; k++) begin
                if (!s1_valid[i] &&
                    req_elig[i][wrap_add(int'(ptr1_q[i]), k, NUM_VCS)]) begin
                    s1_valid[i] = 1'b1;
                    s1_vc[i]    = VW'(wrap_add(int'(ptr1_q[i]), k, NUM_VCS));
                    s1_tgt[i]   = req_tgt[i][wrap_add(int'(ptr1_q[i]), k, NUM_VCS)];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: per output, first stage-1 winner targeting it, from ptr2
    // -------------------------------------------------------------------------
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] s2_sel;     // [output][input]
    logic [NUM_PORTS-1:0]                s2_found;

    always_comb begin
        s2_sel   = '0;
        s2_found = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (!s2_found[o] &&
                    s1_valid[wrap_add(int'(ptr2_q[o]), k, NUM_PORTS)] &&
                    s1_tgt[wrap_add(int'(ptr2_q[o]), k, NUM_PORTS)][o]) begin
                    s2_found[o] = 1'b1;
                    s2_sel[o][wrap_add(int'(ptr2_q[o]), k, NUM_PORTS)] = 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next state: grants and pointer updates
    // A stage-1 winner that loses stage 2 keeps its ptr1, so it is retried
    // first next cycle; this is what bounds the wait of every requester.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_valid_d = '0;
        grant_vc_d    = '0;
        xbar_sel_d    = s2_sel;
        ptr1_d        = ptr1_q;
        ptr2_d        = ptr2_q;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (s2_sel[o][i]) begin
                    grant_valid_d[i]          = 1'b1;
                    grant_vc_d[i][s1_vc[i]]   = 1'b1;
                    ptr1_d[i] = (int'(s1_vc[i]) == NUM_VCS - 1) ? '0 : s1_vc[i] + VW'(1);
                    ptr2_d[o] = (i == NUM_PORTS - 1) ? '0 : PW'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr1_q        <= '0;
            ptr2_q        <= '0;
            grant_valid_q <= '0;
            grant_vc_q    <= '0;
            xbar_sel_q    <= '0;
        end else begin
            ptr1_q        <= ptr1_d;
            ptr2_q        <= ptr2_d;
            grant_valid_q <= grant_valid_d;
            grant_vc_q    <= grant_vc_d;
            xbar_sel_q    <= xbar_sel_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_vc    = grant_vc_q;
    assign xbar_sel    = xbar_sel_q;

endmodule
